sync_dp_ram: RTL and testbench

//  Parametrised simple-dual-port synchronous RAM: one write port, one read port, byte enables.

---
 rtl/sync_dp_ram_pkg.sv | 9 +
 rtl/ram_init_seq.sv | 51 +++++
 rtl/sync_dp_ram.sv | 121 ++++++++++++
 tb/tb_sync_dp_ram.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sync_dp_ram_pkg.sv
// Shared constants and FSM state type for the simple-dual-port RAM.
package sync_dp_ram_pkg;

   localparam int unsigned RDW_OLD = 0;
   localparam int unsigned RDW_NEW = 1;

   typedef enum logic {INIT, READY} state_t;

endpackage

// File: rtl/ram_init_seq.sv
// Post-reset init sweep: walks every word once, then hands the array to the user ports.
module ram_init_seq
   import sync_dp_ram_pkg::*;
#(
   parameter int unsigned ADDR_W  = 6,
   parameter int unsigned DEPTH   = 64,
   parameter int unsigned INIT_EN = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              init_busy,
   output logic              init_we,
   output logic [ADDR_W-1:0] init_addr
);

   localparam state_t            RST_STATE = (INIT_EN != 0) ? INIT : READY;
   localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(DEPTH - 1);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] cnt, cnt_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RST_STATE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (state == INIT) begin
         if (cnt == LAST) begin
            state_nx = READY;
            cnt_nx   = '0;
         end else begin
            cnt_nx = cnt + 1'b1;
         end
      end
   end

   always_comb begin
      init_busy = (state == INIT);
      init_we   = (state == INIT);
      init_addr = cnt;
   end

endmodule

// File: rtl/sync_dp_ram.sv
// Simple-dual-port synchronous RAM with byte enables, selectable read-during-write
// policy, optional output register and a post-reset init sweep.
module sync_dp_ram
   import sync_dp_ram_pkg::*;
#(
   parameter int unsigned       DATA_W   = 8,
   parameter int unsigned       ADDR_W   = 6,
   parameter int unsigned       DEPTH    = 64,
   parameter int unsigned       RDW_MODE = RDW_OLD,
   parameter int unsigned       OUT_REG  = 0,
   parameter int unsigned       INIT_EN  = 1,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W/8-1:0]   wr_be,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  rd_valid,
   output logic                  init_busy,
   output logic                  acc_err
);

   localparam int unsigned       NB      = DATA_W / 8;
   localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

   logic                busy;
   logic                init_we;
   logic [ADDR_W-1:0]   init_addr;
   logic                wr_ok, rd_ok;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [NB-1:0]       mem_be;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W-1:0]   rd_word;
   logic [DATA_W-1:0]   mem [DEPTH];

   ram_init_seq #(
      .ADDR_W  (ADDR_W),
      .DEPTH   (DEPTH),
      .INIT_EN (INIT_EN)
   ) u_init_seq (
      .clk       (clk),
      .rst_n     (rst_n),
      .init_busy (busy),
      .init_we   (init_we),
      .init_addr (init_addr)
   );

   assign init_busy = busy;

   // Out-of-range addresses are rejected outright, never folded onto a valid word.
   always_comb begin
      wr_ok = wr_en & ~busy & ({1'b0, wr_addr} < DEPTH_X);
      rd_ok = rd_en & ~busy & ({1'b0, rd_addr} < DEPTH_X);
   end

   always_comb begin
      mem_we    = busy ? init_we   : wr_ok;
      mem_addr  = busy ? init_addr : wr_addr;
      mem_be    = busy ? '1        : wr_be;
      mem_wdata = busy ? INIT_VAL  : wr_data;
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
   end

   // Write-first mode forwards the enabled write bytes onto a colliding read.
   always_comb begin
      rd_word = mem[rd_addr];
      if (RDW_MODE == RDW_NEW && wr_ok && wr_addr == rd_addr) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (wr_be[b]) rd_word[8*b +: 8] = wr_data[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc_err <= 1'b0;
      else        acc_err <= (wr_en & ~wr_ok) | (rd_en & ~rd_ok);
   end

   if (OUT_REG != 0) begin : g_out2
      logic              s1_valid;
      logic [DATA_W-1:0] s1_data;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
         end else begin
            s1_valid <= rd_ok;
            if (rd_ok) s1_data <= rd_word;
            rd_valid <= s1_valid;
            if (s1_valid) rd_data <= s1_data;
         end
      end
   end else begin : g_out1
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
         end else begin
            rd_valid <= rd_ok;
            if (rd_ok) rd_data <= rd_word;
         end
      end
   end

endmodule

// File: tb/tb_sync_dp_ram.sv
// Two differently configured RAMs share one stimulus stream; a word-level model predicts both.
module tb_sync_dp_ram;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [5:0]  wr_addr = '0;
   logic [5:0]  rd_addr = '0;
   logic [1:0]  wr_be = '0;
   logic [15:0] wr_data = '0;

   logic [7:0]  rd_data_a;
   logic        rd_valid_a, init_busy_a, acc_err_a;
   logic [15:0] rd_data_b;
   logic        rd_valid_b, init_busy_b, acc_err_b;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // model configuration: index 0 = dut a, 1 = dut b
   int          dep  [2] = '{64, 48};
   int          nb   [2] = '{1, 2};
   int          lat  [2] = '{1, 2};
   bit          rdw  [2] = '{1'b0, 1'b1};
   logic [15:0] ival [2] = '{16'h00A5, 16'h5AA5};

   logic [15:0] mm [2][64];
   int          left [2];
   logic        ev [2], pv [2], ea [2];
   logic [15:0] ed [2], pd [2];

   always #5 clk = ~clk;

   sync_dp_ram #(
      .DATA_W(8), .ADDR_W(6), .DEPTH(64), .RDW_MODE(0), .OUT_REG(0),
      .INIT_EN(1), .INIT_VAL(8'hA5)
   ) u_a (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be[0:0]), .wr_data(wr_data[7:0]),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data_a), .rd_valid(rd_valid_a), .init_busy(init_busy_a), .acc_err(acc_err_a)
   );

   sync_dp_ram #(
      .DATA_W(16), .ADDR_W(6), .DEPTH(48), .RDW_MODE(1), .OUT_REG(1),
      .INIT_EN(1), .INIT_VAL(16'h5AA5)
   ) u_b (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data_b), .rd_valid(rd_valid_b), .init_busy(init_busy_b), .acc_err(acc_err_b)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("a.rd_data",   {8'h00, rd_data_a},   ed[0]);
      chk("a.rd_valid",  {15'h0, rd_valid_a},  {15'h0, ev[0]});
      chk("a.init_busy", {15'h0, init_busy_a}, 16'(left[0] > 0));
      chk("a.acc_err",   {15'h0, acc_err_a},   {15'h0, ea[0]});
      chk("b.rd_data",   rd_data_b,            ed[1]);
      chk("b.rd_valid",  {15'h0, rd_valid_b},  {15'h0, ev[1]});
      chk("b.init_busy", {15'h0, init_busy_b}, 16'(left[1] > 0));
      chk("b.acc_err",   {15'h0, acc_err_b},   {15'h0, ea[1]});
   endtask

   // After reset + full sweep every word holds the init value, so the model fills it at once.
   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         left[d] = dep[d];
         ev[d] = 1'b0; pv[d] = 1'b0; ea[d] = 1'b0;
         ed[d] = '0;   pd[d] = '0;
         for (int a = 0; a < 64; a++) mm[d][a] = ival[d];
      end
   endtask

   task automatic model_edge(input int d);
      logic        busy, wok, rok;
      logic [15:0] word;
      busy  = (left[d] > 0);
      wok   = wr_en && !busy && (int'(wr_addr) < dep[d]);
      rok   = rd_en && !busy && (int'(rd_addr) < dep[d]);
      ea[d] = (wr_en && !wok) || (rd_en && !rok);
      word  = mm[d][rd_addr];
      if (rdw[d] && wok && wr_addr == rd_addr)
         for (int b = 0; b < nb[d]; b++) if (wr_be[b]) word[8*b +: 8] = wr_data[8*b +: 8];
      if (wok)
         for (int b = 0; b < nb[d]; b++) if (wr_be[b]) mm[d][wr_addr][8*b +: 8] = wr_data[8*b +: 8];
      if (left[d] > 0) left[d]--;
      if (lat[d] == 1) begin
         ev[d] = rok;
         if (rok) ed[d] = word;
      end else begin
         ev[d] = pv[d];
         if (pv[d]) ed[d] = pd[d];
         pv[d] = rok;
         if (rok) pd[d] = word;
      end
   endtask

   task automatic cycle();
      model_edge(0);
      model_edge(1);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;
   endtask

   task automatic idle(input int n);
      wr_en = 1'b0;
      rd_en = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic wr(input logic [5:0] a, input logic [15:0] d, input logic [1:0] be);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be; rd_en = 1'b0;
      cycle();
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [5:0] a);
      rd_en = 1'b1; rd_addr = a; wr_en = 1'b0;
      cycle();
      rd_en = 1'b0;
   endtask

   initial begin
      do_reset();

      // init sweep, with accesses poked in while busy
      for (int i = 0; i < 70; i++) begin
         rd_en = (i == 3); rd_addr = 6'd0;
         wr_en = (i == 5); wr_addr = 6'd2; wr_be = 2'b11; wr_data = 16'hDEAD;
         cycle();
      end
      idle(1);

      // back-to-back reads of the whole address space (b rejects 48..63)
      for (int a = 0; a < 64; a++) begin
         rd_en = 1'b1; rd_addr = 6'(a);
         cycle();
      end
      idle(3);

      for (int a = 0; a < 5; a++) wr(6'(a), 16'(a), 2'b11);
      for (int a = 0; a < 5; a++) rd(6'(a));
      idle(3);

      wr(6'd7, 16'h1234, 2'b11);
      wr(6'd7, 16'hABCD, 2'b01);
      wr(6'd7, 16'hFFFF, 2'b00);
      rd(6'd7);
      idle(3);

      wr(6'd9, 16'h0011, 2'b11);
      wr_en = 1'b1; wr_addr = 6'd9; wr_data = 16'h0055; wr_be = 2'b11;
      rd_en = 1'b1; rd_addr = 6'd9;
      cycle();
      rd(6'd9);
      idle(3);

      wr(6'd50, 16'hBEEF, 2'b11);
      wr(6'd47, 16'hC0DE, 2'b11);
      wr(6'd48, 16'hFACE, 2'b11);
      rd(6'd50); rd(6'd47); rd(6'd48); rd(6'd63);
      idle(3);

      for (int i = 0; i < 400; i++) begin
         wr_en   = 1'($urandom_range(0, 1));
         rd_en   = 1'($urandom_range(0, 1));
         wr_addr = 6'($urandom_range(0, 63));
         rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 6'($urandom_range(0, 63));
         wr_be   = 2'($urandom);
         wr_data = 16'($urandom);
         cycle();
      end
      idle(3);

      // reset while reads are in flight
      rd_en = 1'b1; rd_addr = 6'd1; cycle();
      rd_addr = 6'd2; cycle();
      rd_en = 1'b0;
      do_reset();

      // reset again at cycle 20 of the sweep
      idle(20);
      do_reset();
      idle(70);
      for (int i = 0; i < 12; i++) rd(6'($urandom_range(0, 63)));
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
